// File: rtl/if_fetch_stage_pkg.sv
// Shared configuration for the instruction-fetch stage: widths, the NOP used
// for exception slots, and the fetch FSM state encoding.
package if_fetch_stage_pkg;

  localparam int SYS_XLEN     = 32;
  localparam int SYS_INST_LEN = 32;

  localparam logic [SYS_XLEN-1:0]     SYS_PC_RESET_ADDR = 32'h8000_0000;
  localparam logic [SYS_INST_LEN-1:0] INST_NOP          = 32'h0000_0013;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_WAIT = 2'd1,
    IF_DROP = 2'd2
  } if_state_e;

  function automatic logic pc_is_aligned(input logic [1:0] pc_lsbs);
    return pc_lsbs == 2'b00;
  endfunction

endpackage

// File: rtl/if_fetch_stage_inst_fifo.sv
// Small synchronous queue between fetch and decode. Power-of-two depth so the
// pointers wrap naturally; the read port reads as zero whenever it is empty.
module if_inst_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 65
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Clear wins over push/pop so a flush never leaves a stale entry behind.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (clear_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) begin
        mem_d[wptr_q] = wdata_i;
        wptr_d        = wptr_q + 1'b1;
      end
      if (pop_i) begin
        rptr_d = rptr_q + 1'b1;
      end
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  assign valid_o = count_q != '0;
  assign rdata_o = valid_o ? mem_q[rptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/if_fetch_stage.sv
// IF stage: issues one I-cache read at a time for the PC register, queues
// {pc, inst, misalign} for decode, stalls the PC and drops fetches on flush.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high at the rising edge; ic_req_valid_o may drop without ready because the
// PC it carries can change, and the response has no ready (a slot is always
// reserved for it).
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int XLEN       = SYS_XLEN,
  parameter int INST_LEN   = SYS_INST_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [XLEN-1:0]     pc_i,
  input  logic                pc_valid_i,
  input  logic                flush_i,
  output logic                stall_o,
  output logic                ic_req_valid_o,
  output logic [XLEN-1:0]     ic_req_addr_o,
  input  logic                ic_req_ready_i,
  input  logic                ic_resp_valid_i,
  input  logic [INST_LEN-1:0] ic_resp_data_i,
  output logic                inst_valid_o,
  output logic [INST_LEN-1:0] inst_o,
  output logic [XLEN-1:0]     inst_pc_o,
  output logic                inst_misalign_o,
  input  logic                id_ready_i,
  output if_state_e           dbg_state_o
);

  localparam int EW = XLEN + INST_LEN + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  if_state_e         state_q, state_d;
  logic [XLEN-1:0]   req_pc_q, req_pc_d;

  logic [CW-1:0]     fifo_count;
  logic [CW:0]       occupancy;
  logic              busy;
  logic              space;
  logic              issue_ok;
  logic              aligned;
  logic              handshake;
  logic              misalign_push;
  logic              resp_push;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_valid;
  logic [EW-1:0]     fifo_wdata;
  logic [EW-1:0]     fifo_rdata;

  // An outstanding request counts as occupied so its response can always push.
  assign busy      = state_q != IF_IDLE;
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, busy};
  assign space     = occupancy < (CW + 1)'(FIFO_DEPTH);
  assign aligned   = pc_is_aligned(pc_i[1:0]);
  assign issue_ok  = (state_q == IF_IDLE) & pc_valid_i & space & ~flush_i;

  assign ic_req_valid_o = issue_ok & aligned;
  assign ic_req_addr_o  = pc_i;
  assign handshake      = ic_req_valid_o & ic_req_ready_i;
  assign misalign_push  = issue_ok & ~aligned;
  assign resp_push      = (state_q == IF_WAIT) & ic_resp_valid_i & ~flush_i;

  assign stall_o = pc_valid_i & ~flush_i & ~(handshake | misalign_push);

  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    case (state_q)
      IF_IDLE: begin
        if (handshake) begin
          state_d  = IF_WAIT;
          req_pc_d = pc_i;
        end
      end
      IF_WAIT: begin
        if (ic_resp_valid_i) begin
          state_d = IF_IDLE;
        end else if (flush_i) begin
          state_d = IF_DROP;
        end
      end
      IF_DROP: begin
        if (ic_resp_valid_i) begin
          state_d = IF_IDLE;
        end
      end
      default: state_d = IF_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IF_IDLE;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
    end
  end

  // A misaligned PC takes a queue slot as a NOP tagged with the exception.
  always_comb begin
    if (misalign_push) begin
      fifo_wdata = {pc_i, INST_LEN'(INST_NOP), 1'b1};
    end else begin
      fifo_wdata = {req_pc_q, ic_resp_data_i, 1'b0};
    end
  end

  assign fifo_push = misalign_push | resp_push;
  assign fifo_pop  = fifo_valid & id_ready_i & ~flush_i;

  if_inst_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_inst_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .clear_i (flush_i),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .valid_o (fifo_valid),
    .count_o (fifo_count)
  );

  assign inst_valid_o = fifo_valid;
  assign {inst_pc_o, inst_o, inst_misalign_o} = fifo_rdata;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: a hand-computed vector table, reset and corner
// sequences, then random traffic checked against a transaction-level model.
module tb_if_fetch_stage;
  import if_fetch_stage_pkg::*;

  localparam int DEPTH = 2;
  localparam int XL    = 32;
  localparam int IL    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [XL-1:0] pc_i = '0;
  logic          pc_valid_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          stall_o;
  logic          ic_req_valid_o;
  logic [XL-1:0] ic_req_addr_o;
  logic          ic_req_ready_i = 1'b0;
  logic          ic_resp_valid_i = 1'b0;
  logic [IL-1:0] ic_resp_data_i = '0;
  logic          inst_valid_o;
  logic [IL-1:0] inst_o;
  logic [XL-1:0] inst_pc_o;
  logic          inst_misalign_o;
  logic          id_ready_i = 1'b0;
  if_state_e     dbg_state_o;

  if_fetch_stage #(.FIFO_DEPTH(DEPTH), .XLEN(XL), .INST_LEN(IL)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_i            (pc_i),
    .pc_valid_i      (pc_valid_i),
    .flush_i         (flush_i),
    .stall_o         (stall_o),
    .ic_req_valid_o  (ic_req_valid_o),
    .ic_req_addr_o   (ic_req_addr_o),
    .ic_req_ready_i  (ic_req_ready_i),
    .ic_resp_valid_i (ic_resp_valid_i),
    .ic_resp_data_i  (ic_resp_data_i),
    .inst_valid_o    (inst_valid_o),
    .inst_o          (inst_o),
    .inst_pc_o       (inst_pc_o),
    .inst_misalign_o (inst_misalign_o),
    .id_ready_i      (id_ready_i),
    .dbg_state_o     (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // A cache response while nothing is outstanding is a protocol error.
  always @(posedge clk) begin
    if (rst && ic_resp_valid_i) begin
      assert (dbg_state_o != IF_IDLE) else $error("cache response while no request outstanding");
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [XL+IL:0] exp_q[$];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic pcv, input logic [XL-1:0] pc, input logic rdy,
                       input logic rv, input logic [IL-1:0] rdata,
                       input logic idr, input logic fl);
    pc_valid_i      = pcv;
    pc_i            = pc;
    ic_req_ready_i  = rdy;
    ic_resp_valid_i = rv;
    ic_resp_data_i  = rdata;
    id_ready_i      = idr;
    flush_i         = fl;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          pcv;
    logic [XL-1:0] pc;
    logic          rdy;
    logic          rv;
    logic [IL-1:0] rdata;
    logic          idr;
    logic          fl;
    logic          e_req;
    logic          e_stall;
    logic          e_iv;
    logic [XL-1:0] e_ipc;
    logic [IL-1:0] e_inst;
    logic          e_mis;
    logic [1:0]    e_st;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic pcv, input logic [XL-1:0] pc, input logic rdy,
                     input logic rv, input logic [IL-1:0] rdata, input logic idr,
                     input logic fl, input logic e_req, input logic e_stall,
                     input logic e_iv, input logic [XL-1:0] e_ipc,
                     input logic [IL-1:0] e_inst, input logic e_mis,
                     input logic [1:0] e_st);
    vec_t v;
    v.pcv = pcv; v.pc = pc; v.rdy = rdy; v.rv = rv; v.rdata = rdata;
    v.idr = idr; v.fl = fl; v.e_req = e_req; v.e_stall = e_stall;
    v.e_iv = e_iv; v.e_ipc = e_ipc; v.e_inst = e_inst; v.e_mis = e_mis;
    v.e_st = e_st;
    vecs.push_back(v);
  endtask

  task automatic check_outputs(input string tag, input logic e_req, input logic [XL-1:0] e_addr,
                               input logic e_stall, input logic e_iv,
                               input logic [XL+IL:0] e_head, input logic [1:0] e_st);
    chk({tag, ".req_valid"}, 96'(ic_req_valid_o), 96'(e_req));
    if (e_req) chk({tag, ".req_addr"}, 96'(ic_req_addr_o), 96'(e_addr));
    chk({tag, ".stall"}, 96'(stall_o), 96'(e_stall));
    chk({tag, ".inst_valid"}, 96'(inst_valid_o), 96'(e_iv));
    chk({tag, ".head"}, 96'({inst_pc_o, inst_o, inst_misalign_o}), 96'(e_head));
    chk({tag, ".state"}, 96'(dbg_state_o), 96'(e_st));
  endtask

  // ---------------- random-phase model state ----------------
  int             mode;
  logic [XL-1:0]  pend_pc;
  logic           cache_pend;
  int             cache_cnt;
  logic [XL-1:0]  cur_pc;
  logic           r_fl, r_pcv, r_rdy, r_idr, r_rv;
  logic [XL-1:0]  r_pc;
  logic [IL-1:0]  r_data;
  logic [31:0]    rr;
  logic           sp, al, e_req, e_hs, e_mis, e_stall;
  logic [XL+IL:0] e_head;

  initial begin
    // Reset values while rst is held low
    drive(0, '0, 0, 0, '0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 1'b0, '0, 1'b0, 1'b0, '0, 2'd0);
    rst = 1'b1;

    // straight-line fetch
    add(1, 32'h80000000, 1, 0, 32'h0,        1, 0, 1, 0, 0, 32'h0,        32'h0,        0, 0);
    add(0, 32'h80000004, 0, 1, 32'h00100093, 1, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1);
    add(1, 32'h80000004, 1, 0, 32'h0,        1, 0, 1, 0, 1, 32'h80000000, 32'h00100093, 0, 0);
    add(0, 32'h80000008, 0, 1, 32'h00200113, 1, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1);
    add(1, 32'h80000008, 1, 0, 32'h0,        1, 0, 1, 0, 1, 32'h80000004, 32'h00200113, 0, 0);
    add(0, 32'h8000000c, 0, 1, 32'h00300193, 1, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1);
    add(0, 32'h8000000c, 0, 0, 32'h0,        1, 0, 0, 0, 1, 32'h80000008, 32'h00300193, 0, 0);
    // misaligned PC becomes a tagged NOP
    add(1, 32'h80000002, 1, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0);
    add(0, 32'h80000006, 0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h80000002, 32'h00000013, 1, 0);
    add(0, 32'h80000006, 0, 0, 32'h0,        1, 0, 0, 0, 1, 32'h80000002, 32'h00000013, 1, 0);
    // cache not ready, then flush while waiting -> DROP
    add(1, 32'h80000010, 0, 0, 32'h0,        0, 0, 1, 1, 0, 32'h0,        32'h0,        0, 0);
    add(1, 32'h80000010, 1, 0, 32'h0,        0, 0, 1, 0, 0, 32'h0,        32'h0,        0, 0);
    add(0, 32'h80000100, 0, 0, 32'h0,        0, 1, 0, 0, 0, 32'h0,        32'h0,        0, 1);
    add(1, 32'h80000100, 1, 0, 32'h0,        0, 0, 0, 1, 0, 32'h0,        32'h0,        0, 2);
    add(1, 32'h80000100, 1, 1, 32'hdeadbeef, 0, 0, 0, 1, 0, 32'h0,        32'h0,        0, 2);
    add(1, 32'h80000100, 1, 0, 32'h0,        0, 0, 1, 0, 0, 32'h0,        32'h0,        0, 0);
    add(0, 32'h80000104, 0, 1, 32'h00000517, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1);
    add(0, 32'h80000104, 0, 0, 32'h0,        1, 0, 0, 0, 1, 32'h80000100, 32'h00000517, 0, 0);
    // flush on the same cycle as the response
    add(1, 32'h80000200, 1, 0, 32'h0,        1, 0, 1, 0, 0, 32'h0,        32'h0,        0, 0);
    add(1, 32'h80000300, 1, 1, 32'hcafef00d, 1, 1, 0, 0, 0, 32'h0,        32'h0,        0, 1);
    add(0, 32'h80000300, 0, 0, 32'h0,        1, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0);
    // decode backpressure fills the queue
    add(1, 32'h80000400, 1, 0, 32'h0,        0, 0, 1, 0, 0, 32'h0,        32'h0,        0, 0);
    add(1, 32'h80000404, 1, 1, 32'h11111111, 0, 0, 0, 1, 0, 32'h0,        32'h0,        0, 1);
    add(1, 32'h80000404, 1, 0, 32'h0,        0, 0, 1, 0, 1, 32'h80000400, 32'h11111111, 0, 0);
    add(1, 32'h80000408, 1, 1, 32'h22222222, 0, 0, 0, 1, 1, 32'h80000400, 32'h11111111, 0, 1);
    add(1, 32'h80000408, 1, 0, 32'h0,        0, 0, 0, 1, 1, 32'h80000400, 32'h11111111, 0, 0);
    add(1, 32'h80000408, 1, 0, 32'h0,        1, 0, 0, 1, 1, 32'h80000400, 32'h11111111, 0, 0);
    add(1, 32'h80000408, 1, 0, 32'h0,        0, 0, 1, 0, 1, 32'h80000404, 32'h22222222, 0, 0);
    add(0, 32'h8000040c, 0, 1, 32'h33333333, 1, 0, 0, 0, 1, 32'h80000404, 32'h22222222, 0, 1);
    add(0, 32'h8000040c, 0, 0, 32'h0,        1, 0, 0, 0, 1, 32'h80000408, 32'h33333333, 0, 0);
    add(0, 32'h8000040c, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0);
    // flush clears a queued entry; the pop that cycle is ignored
    add(1, 32'h80000002, 1, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0);
    add(0, 32'h80000004, 0, 0, 32'h0,        1, 1, 0, 0, 1, 32'h80000002, 32'h00000013, 1, 0);
    add(0, 32'h80000004, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].pcv, vecs[i].pc, vecs[i].rdy, vecs[i].rv, vecs[i].rdata,
            vecs[i].idr, vecs[i].fl);
      @(negedge clk);
      check_outputs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].pc, vecs[i].e_stall,
                    vecs[i].e_iv, {vecs[i].e_ipc, vecs[i].e_inst, vecs[i].e_mis},
                    vecs[i].e_st);
      next_cycle();
    end

    // async reset mid-WAIT with one entry queued
    drive(1, 32'h80000500, 1, 0, '0, 0, 0);
    next_cycle();
    drive(0, 32'h80000504, 0, 1, 32'h0a0a0a0a, 0, 0);
    next_cycle();
    drive(1, 32'h80000504, 1, 0, '0, 0, 0);
    next_cycle();
    drive(0, 32'h80000508, 0, 0, '0, 0, 0);
    #2;
    chk("pre_reset.inst_valid", 96'(inst_valid_o), 96'(1));
    rst = 1'b0;
    #1;
    check_outputs("async_reset", 1'b0, '0, 1'b0, 1'b0, '0, 2'd0);
    next_cycle();
    rst = 1'b1;
    drive(1, 32'h80000600, 1, 0, '0, 0, 0);
    @(negedge clk);
    check_outputs("post_reset_req", 1'b1, 32'h80000600, 1'b0, 1'b0, '0, 2'd0);
    next_cycle();
    drive(0, 32'h80000604, 0, 1, 32'h12345678, 0, 0);
    next_cycle();
    drive(0, 32'h80000604, 0, 0, '0, 1, 0);
    @(negedge clk);
    check_outputs("post_reset_head", 1'b0, '0, 1'b0, 1'b1,
                  {32'h80000600, 32'h12345678, 1'b0}, 2'd0);
    next_cycle();

    // random traffic against the transaction-level model
    exp_q.delete();
    mode       = 0;
    pend_pc    = '0;
    cache_pend = 1'b0;
    cache_cnt  = 0;
    cur_pc     = 32'h80001000;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      r_fl   = ($urandom_range(0, 19) == 0);
      r_pcv  = ($urandom_range(0, 3) != 0);
      r_rdy  = ($urandom_range(0, 2) != 0);
      r_idr  = ($urandom_range(0, 2) != 0);
      r_rv   = cache_pend && (cache_cnt == 0);
      r_data = $urandom();
      r_pc   = cur_pc;

      sp      = (exp_q.size() + (mode != 0 ? 1 : 0)) < DEPTH;
      al      = (r_pc % 4) == 0;
      e_req   = (mode == 0) && r_pcv && sp && !r_fl && al;
      e_hs    = e_req && r_rdy;
      e_mis   = (mode == 0) && r_pcv && sp && !r_fl && !al;
      e_stall = r_pcv && !r_fl && !(e_hs || e_mis);
      e_head  = (exp_q.size() != 0) ? exp_q[0] : '0;

      drive(r_pcv, r_pc, r_rdy, r_rv, r_data, r_idr, r_fl);
      @(negedge clk);
      check_outputs($sformatf("rand%0d", cyc), e_req, r_pc, e_stall,
                    exp_q.size() != 0, e_head, 2'(mode));
      @(posedge clk);

      if (r_fl) begin
        exp_q.delete();
      end else begin
        if (exp_q.size() != 0 && r_idr) void'(exp_q.pop_front());
        if (e_mis) exp_q.push_back({r_pc, INST_NOP, 1'b1});
        if (mode == 1 && r_rv) exp_q.push_back({pend_pc, r_data, 1'b0});
      end

      if (r_rv) cache_pend = 1'b0;
      else if (cache_pend && cache_cnt != 0) cache_cnt--;

      case (mode)
        0: if (e_hs) begin
             mode       = 1;
             pend_pc    = r_pc;
             cache_pend = 1'b1;
             cache_cnt  = $urandom_range(0, 3);
           end
        1: if (r_rv) mode = 0; else if (r_fl) mode = 2;
        default: if (r_rv) mode = 0;
      endcase

      rr = $urandom();
      if (r_fl) cur_pc = {rr[31:2], 2'b00};
      else if (!e_stall) begin
        if (rr[3:0] == 4'd0) cur_pc = {cur_pc[31:2], 2'b00} + 32'd2;
        else cur_pc = {cur_pc[31:2], 2'b00} + 32'd4;
      end
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
